// File: rtl/sha256_compress.sv
// SHA-256 compression engine: sequences the message-schedule stage through one
// 512-bit block, runs the 64 rounds and folds the result into the chaining value.
module sha256_compress (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         first,
  input  logic [31:0]  w0,
  output logic         ld_rgs,
  output logic         upd_rgs,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL
  } state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotations are fixed wiring, so the big-sigma functions are written as slices.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  t_q;
  logic        first_q;
  logic [31:0] wv [8];
  logic [31:0] h_reg [8];
  logic [31:0] t1;
  logic [31:0] t2;

  // State register; reset drops straight back to IDLE even mid-block.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one load cycle, 64 rounds, one chaining-add cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_ROUND;
      S_ROUND: if (t_q == 6'd63) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Round function: T1/T2 from the current working variables and schedule word.
  always_comb begin
    t1 = wv[7] + big_sigma1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
       + K_ROM[t_q] + w0;
    t2 = big_sigma0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
  end

  // Datapath: working variables, chaining value, round counter and done pulse.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 8; i++) begin
        wv[i]    <= '0;
        h_reg[i] <= IV[i];
      end
      t_q     <= '0;
      first_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state_q == S_FINAL);
      case (state_q)
        S_IDLE: begin
          if (start) first_q <= first;
        end
        S_LOAD: begin
          for (int i = 0; i < 8; i++) begin
            if (first_q) begin
              wv[i]    <= IV[i];
              h_reg[i] <= IV[i];
            end else begin
              wv[i] <= h_reg[i];
            end
          end
          t_q <= '0;
        end
        S_ROUND: begin
          wv[7] <= wv[6];
          wv[6] <= wv[5];
          wv[5] <= wv[4];
          wv[4] <= wv[3] + t1;
          wv[3] <= wv[2];
          wv[2] <= wv[1];
          wv[1] <= wv[0];
          wv[0] <= t1 + t2;
          t_q   <= t_q + 6'd1;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
        end
        default: ;
      endcase
    end
  end

  assign ld_rgs  = (state_q != S_LOAD);
  assign upd_rgs = (state_q == S_LOAD) || (state_q == S_ROUND);
  assign busy    = (state_q != S_IDLE);
  assign digest  = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                    h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression engine that consumes the message-schedule word stream and produces the 256-bit chaining value. It sits directly downstream of the message-schedule stage (`sigma_iter`). It drives that stage's `ld_rgs`/`upd_rgs` controls, reads its `w0` output once per round, and runs the 64 rounds plus the final chaining addition. Multi-block messages are hashed by issuing one `start` per 512-bit block, with `first` asserted only on the first block.

## Interface
Parameters:
- none; widths are fixed by SHA-256 (32-bit words, 64 rounds, 256-bit digest).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a block; sampled only in IDLE.
- `first`  in  1  sampled with `start`: 1 = chain from IV, 0 = chain from current `digest`.
- `w0`  in  32  current schedule word W[t] from the message-schedule stage.
- `ld_rgs`  out  1  schedule mux select: 0 = load `blk`, 1 = shift in new word.
- `upd_rgs`  out  1  schedule register enable.
- `busy`  out  1  high from LOAD through FINAL.
- `done`  out  1  one-cycle pulse; `digest` is valid from this cycle until the next FINAL.
- `digest`  out  256  H0..H7, with H0 in bits [255:224].

## Operation
- States: IDLE, LOAD, ROUND, FINAL.
- **IDLE**
  - `start`=1 goes to LOAD and latches `first`.
  - `start` is ignored in every other state.
- **LOAD** (1 cycle)
  - `ld_rgs`=0, `upd_rgs`=1, so the schedule captures `blk`.
  - Working registers a..h ← IV if the latched `first`=1, else ← H0..H7.
  - If `first`=1, H0..H7 ← IV in the same edge.
  - Round counter t ← 0. Go to ROUND.
- **ROUND** (64 cycles, t = 0..63)
  - `ld_rgs`=1, `upd_rgs`=1.
  - `w0` equals W[t] in this cycle.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + `w0`.
  - T2 = Σ0(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - t increments; at t=63 go to FINAL.
- **FINAL** (1 cycle)
  - `upd_rgs`=0.
  - Hi ← Hi + working var i, for i = 0..7 (a..h).
  - Register `done`=1 for the next cycle; go to IDLE.
- Function definitions:
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g).
  - Maj = (a&b)^(a&c)^(b&c).
- All additions are modulo 2^32; carries out of bit 31 are discarded.
- K[0..63] is an internal 64×32 constant ROM holding the FIPS 180-4 constants, indexed by t.
- Decoded outputs:
  - `ld_rgs` = (state != LOAD).
  - `upd_rgs` = (state == LOAD || state == ROUND).
  - `busy` = (state != IDLE).
- Reset values:
  - state = IDLE, t = 0.
  - `done`=0, `busy`=0, `ld_rgs`=1, `upd_rgs`=0.
  - `digest` = IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- Reset asserted mid-block returns immediately to the reset values above. No partial digest is retained.

## Timing
- Edge E0 samples `start` in IDLE.
- E1: LOAD edge (schedule load, a..h init).
- E2..E65: rounds t = 0..63.
- E66: FINAL edge (H update).
- `done`=1 and the new `digest` are visible in the cycle after E66.
- `busy` is high for cycles following E0..E65 and low again after E66.
- `start` may be re-asserted in the same cycle that `done`=1. The state is IDLE then, so that `start` is accepted and the next LOAD occurs at the following edge.
- Back-to-back throughput: one block per 67 cycles.
- `digest` is stable outside FINAL. Exceptions: a LOAD with `first`=1 also reinitialises H to IV, and reset sets `digest` to IV.
- `w0` is sampled only in ROUND. Its value in IDLE, LOAD and FINAL is don't-care.

## Test plan
The bench instantiates the message-schedule stage feeding this block and holds `blk` stable from `start` through LOAD.
- **Empty message.** Padded block 80000000 followed by zeros, `first`=1.
  - Expect `done` exactly 67 cycles after `start`.
  - Expect `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **"abc".** Block 61626380 followed by zeros with length word 00000018, `first`=1.
  - Expect `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits).**
  - Block 1 with `first`=1, then block 2 with `first`=0; block 2 `start` is issued in the `done` cycle of block 1.
  - Expect final `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **Control waveform.**
  - `ld_rgs`=0 only in the LOAD cycle.
  - `upd_rgs`=1 for exactly 65 consecutive cycles per block.
  - `start` pulses during ROUND are ignored: no restart, same digest.
- **Reset mid-block.** Assert `rst_b`=0 at round t=30 of "abc".
  - Expect `busy`=0, `done`=0 and `digest`=IV immediately, without waiting for an edge.
  - A subsequent "abc" run gives the correct digest.
- **Re-chain to IV.** After a two-block run, hash "abc" with `first`=1.
  - Expect the "abc" digest, not a chained value.
